// File: rtl/l2_line_adapter_if.sv
// ---------------------------------------------------------------------------
// l2_line_adapter_if
// Purpose : cache-facing physical-memory port of the L2 line adapter. One
//           256-bit line read or write per transaction, held by the cache
//           until a one-cycle completion pulse comes back.
// Signals :
//   pmem_read     cache -> adapter  line-read request, held until pmem_resp
//   pmem_write    cache -> adapter  line-write request, held until pmem_resp
//   pmem_address  cache -> adapter  line address, low offset bits ignored
//   pmem_wdata    cache -> adapter  writeback line
//   pmem_resp     adapter -> cache  one-cycle transaction completion
//   pmem_rdata    adapter -> cache  assembled read line
// Modports: master = cache side, slave = adapter side.
// ---------------------------------------------------------------------------
interface l2_line_adapter_if #(
  parameter int LINE_WIDTH = 256
);
  logic                  pmem_read;
  logic                  pmem_write;
  logic [31:0]           pmem_address;
  logic [LINE_WIDTH-1:0] pmem_wdata;
  logic                  pmem_resp;
  logic [LINE_WIDTH-1:0] pmem_rdata;

  modport master (
    output pmem_read,
    output pmem_write,
    output pmem_address,
    output pmem_wdata,
    input  pmem_resp,
    input  pmem_rdata
  );

  modport slave (
    input  pmem_read,
    input  pmem_write,
    input  pmem_address,
    input  pmem_wdata,
    output pmem_resp,
    output pmem_rdata
  );
endinterface

// File: rtl/l2_line_adapter.sv
// ---------------------------------------------------------------------------
// l2_line_adapter
// Purpose : responder for the L2 cache physical-memory port. Each line
//           transaction is split into a burst of BEATS beats of BEAT_WIDTH
//           bits on the main-memory side. Read beats are assembled into a
//           line that is presented with a one-cycle pmem_resp pulse.
// Ports   :
//   clk               clock
//   rst               synchronous active-high reset
//   io_pmem (slave)   cache-facing line interface (l2_line_adapter_if)
//   i_burst_resp      memory accepts/returns one beat this cycle
//   i_burst_rdata     read beat data
//   o_burst_address   line-aligned memory address (registered)
//   o_burst_wdata     write beat data (registered)
//   o_burst_read      memory read request
//   o_burst_write     memory write request
//   o_err             watchdog abort flag (0 unless watchdog is built in)
// Optional: define L2_LINE_ADAPTER_WATCHDOG_EN to build a stall watchdog.
//           After TIMEOUT consecutive RD/WR cycles without i_burst_resp the
//           transaction is forced to DONE with o_err raised; o_err clears on
//           the next accepted request. Without the macro o_err is tied 0 and
//           an unresponsive memory stalls the adapter indefinitely.
// ---------------------------------------------------------------------------
module l2_line_adapter #(
  parameter int LINE_WIDTH = 256,
  parameter int BEAT_WIDTH = 64,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  l2_line_adapter_if.slave      io_pmem,
  input  logic                  i_burst_resp,
  input  logic [BEAT_WIDTH-1:0] i_burst_rdata,
  output logic [31:0]           o_burst_address,
  output logic [BEAT_WIDTH-1:0] o_burst_wdata,
  output logic                  o_burst_read,
  output logic                  o_burst_write,
  output logic                  o_err
);

  localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
  localparam int CNT_W = $clog2(BEATS);
  localparam int OFS_W = $clog2(LINE_WIDTH / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_inc;
  logic [LINE_WIDTH-1:0] r_line;        // write line, or read line under assembly
  logic [LINE_WIDTH-1:0] r_pmem_rdata;  // last completed read line
  logic [LINE_WIDTH-1:0] w_rd_line;
  logic [31:0]           r_burst_address;
  logic [BEAT_WIDTH-1:0] r_burst_wdata;
  logic                  r_burst_read;
  logic                  r_burst_write;
  logic                  r_pmem_resp;
  logic                  w_burst_read;
  logic                  w_burst_write;
  logic                  w_pmem_resp;
  logic                  w_busy;
  logic                  w_last_beat;
  logic                  w_accept;
  logic                  w_timeout;

  assign w_busy      = (r_state == S_RD) || (r_state == S_WR);
  assign w_last_beat = w_busy && i_burst_resp && (r_cnt == LAST_BEAT);
  assign w_accept    = (r_state == S_IDLE) && (io_pmem.pmem_read || io_pmem.pmem_write);
  assign w_cnt_inc   = r_cnt + CNT_W'(1);

  // Line as it will look once the beat arriving this cycle is stored; lets
  // the final beat go straight into pmem_rdata on the DONE transition.
  always_comb begin
    w_rd_line = r_line;
    w_rd_line[r_cnt*BEAT_WIDTH +: BEAT_WIDTH] = i_burst_rdata;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic. Write wins over a simultaneous read; the read is
  // picked up again by the IDLE sample after DONE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (io_pmem.pmem_write) begin
          w_next = S_WR;
        end else if (io_pmem.pmem_read) begin
          w_next = S_RD;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_RD, S_WR: begin
        if (w_last_beat || w_timeout) begin
          w_next = S_DONE;
        end else begin
          w_next = r_state;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output decode from the next state, so the registered control outputs
  // are aligned with the state they belong to.
  always_comb begin
    w_burst_read  = 1'b0;
    w_burst_write = 1'b0;
    w_pmem_resp   = 1'b0;
    case (w_next)
      S_RD:    w_burst_read  = 1'b1;
      S_WR:    w_burst_write = 1'b1;
      S_DONE:  w_pmem_resp   = 1'b1;
      default: w_pmem_resp   = 1'b0;
    endcase
  end

  // Output registers and beat datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_burst_read    <= 1'b0;
      r_burst_write   <= 1'b0;
      r_pmem_resp     <= 1'b0;
      r_burst_address <= 32'd0;
      r_burst_wdata   <= '0;
      r_line          <= '0;
      r_pmem_rdata    <= '0;
      r_cnt           <= '0;
    end else begin
      r_burst_read  <= w_burst_read;
      r_burst_write <= w_burst_write;
      r_pmem_resp   <= w_pmem_resp;
      case (r_state)
        S_IDLE: begin
          if (io_pmem.pmem_write) begin
            r_burst_address <= {io_pmem.pmem_address[31:OFS_W], {OFS_W{1'b0}}};
            r_line          <= io_pmem.pmem_wdata;
            r_burst_wdata   <= io_pmem.pmem_wdata[BEAT_WIDTH-1:0];
            r_cnt           <= '0;
          end else if (io_pmem.pmem_read) begin
            r_burst_address <= {io_pmem.pmem_address[31:OFS_W], {OFS_W{1'b0}}};
            r_cnt           <= '0;
          end
        end
        S_RD: begin
          if (i_burst_resp) begin
            r_line[r_cnt*BEAT_WIDTH +: BEAT_WIDTH] <= i_burst_rdata;
            r_cnt <= w_cnt_inc;
            if (r_cnt == LAST_BEAT) begin
              r_pmem_rdata <= w_rd_line;
            end
          end
        end
        S_WR: begin
          // Present the next beat once memory has taken the current one.
          if (i_burst_resp) begin
            r_cnt         <= w_cnt_inc;
            r_burst_wdata <= r_line[w_cnt_inc*BEAT_WIDTH +: BEAT_WIDTH];
          end
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

`ifdef L2_LINE_ADAPTER_WATCHDOG_EN
  logic [31:0] r_wd_cnt;
  logic        r_err;

  // Counts consecutive stalled RD/WR cycles; any beat restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wd_cnt <= 32'd0;
    end else if (w_busy && !i_burst_resp) begin
      r_wd_cnt <= r_wd_cnt + 32'd1;
    end else begin
      r_wd_cnt <= 32'd0;
    end
  end

  // The TIMEOUT-th consecutive stalled cycle forces DONE.
  assign w_timeout = w_busy && !i_burst_resp && (r_wd_cnt == 32'(TIMEOUT - 1));

  // Abort flag: set alongside the forced pmem_resp, held until a new request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end else begin
      r_err <= r_err;
    end
  end

  assign o_err = r_err;
`else
  assign w_timeout = 1'b0;
  assign o_err     = 1'b0;
`endif

  assign o_burst_address    = r_burst_address;
  assign o_burst_wdata      = r_burst_wdata;
  assign o_burst_read       = r_burst_read;
  assign o_burst_write      = r_burst_write;
  assign io_pmem.pmem_resp  = r_pmem_resp;
  assign io_pmem.pmem_rdata = r_pmem_rdata;

endmodule

// File: tb/tb_l2_line_adapter.sv
// ---------------------------------------------------------------------------
// tb_l2_line_adapter
// Self-checking bench for l2_line_adapter. Each scenario task drives the
// cache and memory sides cycle by cycle; the expected pmem_rdata of every
// transaction is queued when the request is issued and popped when the DUT
// raises pmem_resp.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_l2_line_adapter;

`ifdef L2_LINE_ADAPTER_WATCHDOG_EN
  localparam int TB_TIMEOUT = 8;
`else
  localparam int TB_TIMEOUT = 1024;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        burst_resp;
  logic [63:0] burst_rdata;
  logic [31:0] burst_address;
  logic [63:0] burst_wdata;
  logic        burst_read;
  logic        burst_write;
  logic        err;

  int total = 0;
  int bad   = 0;

  logic [255:0] exp_q[$];
  logic [255:0] last_rd;   // line the DUT should be holding on pmem_rdata
  logic [255:0] popped;

  l2_line_adapter_if pm ();

  l2_line_adapter #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk             (clk),
    .rst             (rst),
    .io_pmem         (pm),
    .i_burst_resp    (burst_resp),
    .i_burst_rdata   (burst_rdata),
    .o_burst_address (burst_address),
    .o_burst_wdata   (burst_wdata),
    .o_burst_read    (burst_read),
    .o_burst_write   (burst_write),
    .o_err           (err)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are observed 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rep(input logic [7:0] b);
    return {8{b}};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    pm.pmem_read = 1'b0; pm.pmem_write = 1'b0;
    pm.pmem_address = 32'd0; pm.pmem_wdata = '0;
    burst_resp = 1'b0; burst_rdata = 64'd0;
    repeat (3) tick();
    total++;
    if ({pm.pmem_resp, burst_read, burst_write, err} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=0000", {pm.pmem_resp, burst_read, burst_write, err});
    end
    total++;
    if ({burst_address, burst_wdata, pm.pmem_rdata} !== 352'd0) begin
      bad++;
      $display("FAIL reset_data got addr=%h wdata=%h rdata=%h want all 0", burst_address, burst_wdata, pm.pmem_rdata);
    end
    rst = 1'b0;
    tick();
    total++;
    if ({pm.pmem_resp, burst_read, burst_write} !== 3'b000) begin
      bad++;
      $display("FAIL reset_idle got=%b want=000", {pm.pmem_resp, burst_read, burst_write});
    end
    last_rd = '0;
  endtask

  task automatic test_read_contig();
    logic [63:0] bt[4];
    bt[0] = rep(8'h11); bt[1] = rep(8'h22); bt[2] = rep(8'h33); bt[3] = rep(8'h44);
    pm.pmem_read = 1'b1; pm.pmem_address = 32'h0000_1234;
    exp_q.push_back({bt[3], bt[2], bt[1], bt[0]});
    tick();
    total++;
    if ({burst_read, burst_write, burst_address} !== {2'b10, 32'h0000_1220}) begin
      bad++;
      $display("FAIL rd_start got rd/wr=%b%b addr=%h want 10 00001220", burst_read, burst_write, burst_address);
    end
    for (int i = 0; i < 4; i++) begin
      burst_resp = 1'b1; burst_rdata = bt[i];
      tick();
      if (i < 3) begin
        total++;
        if ({pm.pmem_resp, burst_read} !== 2'b01) begin
          bad++;
          $display("FAIL rd_beat%0d got resp/rd=%b want 01", i, {pm.pmem_resp, burst_read});
        end
      end
    end
    burst_resp = 1'b0;
    total++;
    if (pm.pmem_resp !== 1'b1) begin
      bad++;
      $display("FAIL rd_resp got=%b want=1", pm.pmem_resp);
    end
    if (pm.pmem_resp === 1'b1) begin
      popped = exp_q.pop_front();
      last_rd = popped;
      total++;
      if (pm.pmem_rdata !== popped) begin
        bad++;
        $display("FAIL rd_line got=%h want=%h", pm.pmem_rdata, popped);
      end
    end
    pm.pmem_read = 1'b0;
    tick();
    total++;
    if ({pm.pmem_resp, burst_read} !== 2'b00) begin
      bad++;
      $display("FAIL rd_after got resp/rd=%b want 00", {pm.pmem_resp, burst_read});
    end
  endtask

  task automatic test_write_gaps();
    logic [63:0] d[5];
    int pat[7] = '{1, 0, 0, 1, 1, 0, 1};
    int n = 0;
    d[0] = 64'h0123_4567_89AB_CDEF; d[1] = 64'hFEDC_BA98_7654_3210;
    d[2] = 64'h0F0F_1E1E_2D2D_3C3C; d[3] = 64'hDEAD_BEEF_CAFE_F00D;
    d[4] = 64'd0;
    pm.pmem_write = 1'b1; pm.pmem_address = 32'h0000_805F;
    pm.pmem_wdata = {d[3], d[2], d[1], d[0]};
    exp_q.push_back(last_rd);
    tick();
    total++;
    if ({burst_write, burst_read, burst_address, burst_wdata} !== {2'b10, 32'h0000_8040, d[0]}) begin
      bad++;
      $display("FAIL wr_start got wr/rd=%b%b addr=%h wdata=%h want 10 00008040 %h", burst_write, burst_read, burst_address, burst_wdata, d[0]);
    end
    for (int i = 0; i < 7; i++) begin
      burst_resp = (pat[i] == 1); burst_rdata = rep(8'h5A);
      tick();
      n += pat[i];
      if (n < 4) begin
        total++;
        if ({pm.pmem_resp, burst_write, burst_wdata} !== {2'b01, d[n]}) begin
          bad++;
          $display("FAIL wr_gap%0d got resp/wr=%b wdata=%h want 01 %h", i, {pm.pmem_resp, burst_write}, burst_wdata, d[n]);
        end
      end
    end
    burst_resp = 1'b0;
    total++;
    if (pm.pmem_resp !== 1'b1) begin
      bad++;
      $display("FAIL wr_resp got=%b want=1", pm.pmem_resp);
    end
    if (pm.pmem_resp === 1'b1) begin
      popped = exp_q.pop_front();
      total++;
      if (pm.pmem_rdata !== popped) begin
        bad++;
        $display("FAIL wr_rdata_kept got=%h want=%h", pm.pmem_rdata, popped);
      end
    end
    pm.pmem_write = 1'b0;
    tick();
    total++;
    if ({pm.pmem_resp, burst_write} !== 2'b00) begin
      bad++;
      $display("FAIL wr_after got resp/wr=%b want 00", {pm.pmem_resp, burst_write});
    end
  endtask

  task automatic test_simultaneous();
    logic [63:0] r[4];
    r[0] = rep(8'hA1); r[1] = rep(8'hB2); r[2] = rep(8'hC3); r[3] = rep(8'hD4);
    pm.pmem_read = 1'b1; pm.pmem_write = 1'b1; pm.pmem_address = 32'h2000_0000;
    pm.pmem_wdata = {4{64'h5555_AAAA_5555_AAAA}};
    exp_q.push_back(last_rd);
    tick();
    total++;
    if ({burst_write, burst_read} !== 2'b10) begin
      bad++;
      $display("FAIL both_wr_first got wr/rd=%b want 10", {burst_write, burst_read});
    end
    for (int i = 0; i < 4; i++) begin
      burst_resp = 1'b1; burst_rdata = rep(8'hEE);
      tick();
    end
    burst_resp = 1'b0;
    total++;
    if (pm.pmem_resp !== 1'b1) begin
      bad++;
      $display("FAIL both_wr_resp got=%b want=1", pm.pmem_resp);
    end
    if (pm.pmem_resp === 1'b1) begin
      popped = exp_q.pop_front();
      total++;
      if (pm.pmem_rdata !== popped) begin
        bad++;
        $display("FAIL both_wr_rdata got=%h want=%h", pm.pmem_rdata, popped);
      end
    end
    pm.pmem_write = 1'b0;
    tick();
    total++;
    if ({pm.pmem_resp, burst_read, burst_write} !== 3'b000) begin
      bad++;
      $display("FAIL both_idle got=%b want=000", {pm.pmem_resp, burst_read, burst_write});
    end
    exp_q.push_back({r[3], r[2], r[1], r[0]});
    tick();
    total++;
    if ({burst_read, burst_write, burst_address} !== {2'b10, 32'h2000_0000}) begin
      bad++;
      $display("FAIL both_rd_follow got rd/wr=%b%b addr=%h want 10 20000000", burst_read, burst_write, burst_address);
    end
    for (int i = 0; i < 4; i++) begin
      burst_resp = 1'b1; burst_rdata = r[i];
      tick();
    end
    burst_resp = 1'b0;
    total++;
    if (pm.pmem_resp !== 1'b1) begin
      bad++;
      $display("FAIL both_rd_resp got=%b want=1", pm.pmem_resp);
    end
    if (pm.pmem_resp === 1'b1) begin
      popped = exp_q.pop_front();
      last_rd = popped;
      total++;
      if (pm.pmem_rdata !== popped) begin
        bad++;
        $display("FAIL both_rd_line got=%h want=%h", pm.pmem_rdata, popped);
      end
    end
    pm.pmem_read = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_read();
    logic [63:0] nb[4];
    int k = 0;
    nb[0] = rep(8'h0A); nb[1] = rep(8'h0B); nb[2] = rep(8'h0C); nb[3] = rep(8'h0D);
    pm.pmem_read = 1'b1; pm.pmem_address = 32'h4444_4444;
    tick();
    burst_resp = 1'b1; burst_rdata = rep(8'hEE); tick();
    burst_rdata = rep(8'hDD); tick();
    rst = 1'b1; burst_resp = 1'b0; pm.pmem_read = 1'b0;
    tick();
    total++;
    if ({pm.pmem_resp, burst_read, burst_write, err} !== 4'b0000) begin
      bad++;
      $display("FAIL midrst_ctrl got=%b want=0000", {pm.pmem_resp, burst_read, burst_write, err});
    end
    total++;
    if ({burst_address, burst_wdata, pm.pmem_rdata} !== 352'd0) begin
      bad++;
      $display("FAIL midrst_data got addr=%h wdata=%h rdata=%h want all 0", burst_address, burst_wdata, pm.pmem_rdata);
    end
    rst = 1'b0;
    last_rd = '0;
    tick();
    pm.pmem_read = 1'b1; pm.pmem_address = 32'h0000_0100;
    exp_q.push_back({nb[3], nb[2], nb[1], nb[0]});
    tick();
    for (int c = 0; c < 5; c++) begin
      burst_resp = (c != 2);
      burst_rdata = (c == 2) ? rep(8'hFF) : nb[k];
      tick();
      if (c != 2) k++;
    end
    burst_resp = 1'b0;
    total++;
    if (pm.pmem_resp !== 1'b1) begin
      bad++;
      $display("FAIL midrst_new_resp got=%b want=1", pm.pmem_resp);
    end
    if (pm.pmem_resp === 1'b1) begin
      popped = exp_q.pop_front();
      last_rd = popped;
      total++;
      if (pm.pmem_rdata !== popped) begin
        bad++;
        $display("FAIL midrst_new_line got=%h want=%h", pm.pmem_rdata, popped);
      end
    end
    pm.pmem_read = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [255:0] wl;
    wl = {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888,
          64'h9999_AAAA_BBBB_CCCC, 64'hDDDD_EEEE_FFFF_0000};
    pm.pmem_write = 1'b1; pm.pmem_address = 32'h0000_3000; pm.pmem_wdata = wl;
    exp_q.push_back(last_rd);
    tick();
    for (int i = 0; i < 4; i++) begin
      burst_resp = 1'b1; burst_rdata = 64'd0;
      tick();
    end
    burst_resp = 1'b0;
    total++;
    if (pm.pmem_resp !== 1'b1) begin
      bad++;
      $display("FAIL b2b_wr_resp got=%b want=1", pm.pmem_resp);
    end
    if (pm.pmem_resp === 1'b1) begin
      popped = exp_q.pop_front();
      total++;
      if (pm.pmem_rdata !== popped) begin
        bad++;
        $display("FAIL b2b_wr_rdata got=%h want=%h", pm.pmem_rdata, popped);
      end
    end
    pm.pmem_write = 1'b0; pm.pmem_read = 1'b1;
    exp_q.push_back(wl);
    tick();
    total++;
    if (pm.pmem_resp !== 1'b0) begin
      bad++;
      $display("FAIL b2b_wr_width got=%b want=0", pm.pmem_resp);
    end
    tick();
    total++;
    if ({burst_read, burst_address} !== {1'b1, 32'h0000_3000}) begin
      bad++;
      $display("FAIL b2b_rd_start got rd=%b addr=%h want 1 00003000", burst_read, burst_address);
    end
    for (int i = 0; i < 4; i++) begin
      burst_resp = 1'b1; burst_rdata = wl[i*64 +: 64];
      tick();
    end
    burst_resp = 1'b0;
    total++;
    if (pm.pmem_resp !== 1'b1) begin
      bad++;
      $display("FAIL b2b_rd_resp got=%b want=1", pm.pmem_resp);
    end
    if (pm.pmem_resp === 1'b1) begin
      popped = exp_q.pop_front();
      last_rd = popped;
      total++;
      if (pm.pmem_rdata !== popped) begin
        bad++;
        $display("FAIL b2b_rd_line got=%h want=%h", pm.pmem_rdata, popped);
      end
    end
    pm.pmem_read = 1'b0;
    tick();
    total++;
    if ({pm.pmem_resp, err} !== 2'b00) begin
      bad++;
      $display("FAIL b2b_rd_width got resp/err=%b want 00", {pm.pmem_resp, err});
    end
  endtask

`ifdef L2_LINE_ADAPTER_WATCHDOG_EN
  task automatic test_watchdog();
    int seen = 0;
    pm.pmem_read = 1'b1; pm.pmem_address = 32'h0000_0600;
    exp_q.push_back(last_rd);
    tick();
    for (int c = 1; c <= 20 && seen == 0; c++) begin
      tick();
      if (pm.pmem_resp === 1'b1) seen = c;
    end
    total++;
    if (seen != 8 || err !== 1'b1) begin
      bad++;
      $display("FAIL wd_abort got cycle=%0d err=%b want cycle=8 err=1", seen, err);
    end
    if (pm.pmem_resp === 1'b1) begin
      popped = exp_q.pop_front();
      total++;
      if (pm.pmem_rdata !== popped) begin
        bad++;
        $display("FAIL wd_rdata_kept got=%h want=%h", pm.pmem_rdata, popped);
      end
    end
    pm.pmem_read = 1'b0;
    tick();
    total++;
    if ({pm.pmem_resp, err} !== 2'b01) begin
      bad++;
      $display("FAIL wd_err_hold got resp/err=%b want 01", {pm.pmem_resp, err});
    end
    pm.pmem_write = 1'b1; pm.pmem_wdata = '0;
    exp_q.push_back(last_rd);
    tick();
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL wd_err_clear got=%b want=0", err);
    end
    for (int i = 0; i < 4; i++) begin
      burst_resp = 1'b1;
      tick();
    end
    burst_resp = 1'b0;
    if (pm.pmem_resp === 1'b1) void'(exp_q.pop_front());
    pm.pmem_write = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_read_contig();
    test_write_gaps();
    test_simultaneous();
    test_reset_mid_read();
    test_back_to_back();
`ifdef L2_LINE_ADAPTER_WATCHDOG_EN
    test_watchdog();
`endif
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d entries want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "bench time limit reached");
  end

endmodule
